mem_copy_engine: RTL and testbench

//  Bus initiator for the data_memory port: copies or fills a block of 64-bit doublewords

---
 rtl/mem_copy_engine.sv | 166 ++++++++++++++++
 tb/tb_mem_copy_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator for the data_memory port. It copies a block of 64-bit
//   doublewords from src to dst, or fills dst with a constant pattern, so the
//   core does not have to. It drives the same signal set that the core drives.
//   Only one initiator owns the port at a time; the mux sits at the top level.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle request, sampled only in IDLE
//   mode_i         0 = copy src->dst, 1 = fill dst with fill_value_i
//   src_addr_i     copy source byte address (bits [2:0] ignored)
//   dst_addr_i     destination byte address (bits [2:0] ignored)
//   len_i          number of doublewords to transfer
//   fill_value_i   pattern written in fill mode
//   abort_i        stop an active transfer; the access in the current cycle completes
//   busy_o         high while a transfer is in RD/WR
//   done_o         one-cycle pulse when a transfer completes normally
//   W_en_o/R_en_o  data_memory write/read enables (never both high)
//   addr_o         data_memory byte address
//   RW_type_o      access type, always doubleword (3'b011)
//   WD_o           data_memory write data
//   RD_i           data_memory read data, combinational from addr_o
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i
// RD    | copy only: read src word into buffer
// WR    | write buffer (copy) or fill value (fill) to dst, advance pointers
// FIN   | one-cycle done pulse, then back to IDLE

module mem_copy_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] src_addr_i,
    input  logic [DATA_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] fill_value_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  W_en_o,
    output logic                  R_en_o,
    output logic [DATA_WIDTH-1:0] addr_o,
    output logic [2:0]            RW_type_o,
    output logic [DATA_WIDTH-1:0] WD_o,
    input  logic [DATA_WIDTH-1:0] RD_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(8);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    // Last driven addr/WD, so the bus holds its value outside RD/WR.
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        buf_d     = buf_q;
        W_en_o    = 1'b0;
        R_en_o    = 1'b0;
        addr_o    = addr_q;
        WD_o      = wd_q;
        RW_type_o = 3'b011;
        busy_o    = (state_q == S_RD) || (state_q == S_WR);
        done_o    = (state_q == S_FIN);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d  = {src_addr_i[DATA_WIDTH-1:3], 3'b000};
                    dst_d  = {dst_addr_i[DATA_WIDTH-1:3], 3'b000};
                    rem_d  = len_i;
                    mode_d = mode_i;
                    fill_d = fill_value_i;
                    if (len_i == '0) begin
                        state_d = S_FIN;
                    end else if (mode_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                R_en_o  = 1'b1;
                addr_o  = src_q;
                buf_d   = RD_i;
                state_d = abort_i ? S_IDLE : S_WR;
            end
            S_WR: begin
                W_en_o = 1'b1;
                addr_o = dst_q;
                WD_o   = mode_q ? fill_q : buf_q;
                dst_d  = dst_q + STEP;
                src_d  = src_q + STEP;
                rem_d  = rem_q - LEN_WIDTH'(1);
                // Abort takes priority over completion: no done pulse.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = mode_q ? S_WR : S_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_d = addr_o;
        wd_d   = WD_o;
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [63:0] src = '0;
    logic [63:0] dst = '0;
    logic [15:0] len = '0;
    logic [63:0] fillv = '0;
    logic        abort = 1'b0;
    logic        busy, done, W_en, R_en;
    logic [63:0] addr, WD, RD;
    logic [2:0]  RW_type;

    int n_chk = 0;
    int n_fail = 0;

    // 2 KB data memory, indexed by addr[10:3]
    logic [63:0] mem    [256];
    logic [63:0] refmem [256];

    // access record: {is_write, addr, data}
    logic [128:0] obs_q[$];
    logic [128:0] exp_q[$];
    int obs_done, obs_fall, obs_both, obs_rwt_bad, exp_done;

    always #5 clk = ~clk;

    assign RD = R_en ? mem[addr[10:3]] : 64'd0;

    always @(posedge clk) begin
        if (rst_n && W_en) mem[addr[10:3]] <= WD;
    end

    mem_copy_engine #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_value_i(fillv),
        .abort_i(abort), .busy_o(busy), .done_o(done), .W_en_o(W_en),
        .R_en_o(R_en), .addr_o(addr), .RW_type_o(RW_type), .WD_o(WD), .RD_i(RD)
    );

    // Reference: transfer as a plain loop over doublewords.
    task automatic model(input logic m, input logic [63:0] s, input logic [63:0] d,
                         input int n, input logic [63:0] f);
        logic [63:0] sa, da, v;
        exp_q.delete();
        sa = s & ~64'd7;
        da = d & ~64'd7;
        for (int i = 0; i < n; i++) begin
            if (m) begin
                v = f;
            end else begin
                v = refmem[sa[10:3]];
                exp_q.push_back({1'b0, sa, v});
            end
            exp_q.push_back({1'b1, da, v});
            refmem[da[10:3]] = v;
            sa = sa + 64'd8;
            da = da + 64'd8;
        end
        exp_done = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    endtask

    task automatic run_xfer(input logic m, input logic [63:0] s, input logic [63:0] d,
                            input logic [15:0] n, input logic [63:0] f,
                            input int abort_wr, input int restart_cyc);
        int wcnt;
        wcnt = 0;
        obs_q.delete();
        obs_done = 0; obs_fall = 0; obs_both = 0; obs_rwt_bad = 0;
        @(negedge clk);
        mode = m; src = s; dst = d; len = n; fillv = f; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (cyc == restart_cyc) begin
                start = 1'b1; mode = ~m; dst = 64'h700; len = 16'd1;
            end
            if (W_en && R_en) obs_both++;
            if (RW_type !== 3'b011) obs_rwt_bad++;
            if (R_en) obs_q.push_back({1'b0, addr, RD});
            if (W_en) begin
                obs_q.push_back({1'b1, addr, WD});
                wcnt++;
                if (wcnt == abort_wr) abort = 1'b1;
            end
            if (!busy && obs_fall == 0) obs_fall = cyc;
            if (done) begin
                obs_done = cyc;
                break;
            end
            if (!busy) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_chk++; if (W_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %0b want 0", W_en); end
        n_chk++; if (R_en !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %0b want 0", R_en); end
        n_chk++; if (addr !== 64'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
        n_chk++; if (WD !== 64'd0) begin n_fail++; $display("FAIL reset_wd got %h want 0", WD); end
        n_chk++; if (RW_type !== 3'b011) begin n_fail++; $display("FAIL reset_rwtype got %b want 011", RW_type); end
    endtask

    task automatic test_fill();
        model(1'b1, 64'h0, 64'h100, 4, {16{4'hA}});
        run_xfer(1'b1, 64'h0, 64'h100, 16'd4, {16{4'hA}}, 0, 0);
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fill_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_acc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (obs_done !== 5) begin n_fail++; $display("FAIL fill_done_cycle got %0d want 5", obs_done); end
        n_chk++; if (obs_fall !== 5) begin n_fail++; $display("FAIL fill_busy_fall got %0d want 5", obs_fall); end
        @(negedge clk);
        n_chk++; if (addr !== 64'h118 || WD !== {16{4'hA}}) begin n_fail++; $display("FAIL fill_hold got %h/%h want 118/%h", addr, WD, {16{4'hA}}); end
    endtask

    task automatic test_copy();
        mem[0] = 64'd1; mem[1] = 64'd2; mem[2] = 64'd3;
        refmem[0] = 64'd1; refmem[1] = 64'd2; refmem[2] = 64'd3;
        model(1'b0, 64'h0, 64'h80, 3, 64'd0);
        run_xfer(1'b0, 64'h0, 64'h80, 16'd3, 64'd0, 0, 0);
        n_chk++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL copy_count got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL copy_acc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (obs_done !== 7) begin n_fail++; $display("FAIL copy_done_cycle got %0d want 7", obs_done); end
        n_chk++; if (obs_both !== 0) begin n_fail++; $display("FAIL copy_r_and_w got %0d want 0", obs_both); end
    endtask

    task automatic test_len0_misalign();
        model(1'b0, 64'h40, 64'h140, 0, 64'd0);
        run_xfer(1'b0, 64'h40, 64'h140, 16'd0, 64'd0, 0, 0);
        n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL len0_access got %0d want 0", obs_q.size()); end
        n_chk++; if (obs_done !== 1) begin n_fail++; $display("FAIL len0_done_cycle got %0d want 1", obs_done); end
        model(1'b1, 64'h0, 64'h105, 2, 64'h1234_5678_9ABC_DEF0);
        run_xfer(1'b1, 64'h3, 64'h105, 16'd2, 64'h1234_5678_9ABC_DEF0, 0, 0);
        n_chk++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL misalign_count got %0d want 2", obs_q.size()); end
        else begin
            n_chk++; if (obs_q[0][127:64] !== 64'h100) begin n_fail++; $display("FAIL misalign_addr got %h want 100", obs_q[0][127:64]); end
            n_chk++; if (obs_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL misalign_acc1 got %h want %h", obs_q[1], exp_q[1]); end
        end
    endtask

    task automatic test_abort();
        model(1'b0, 64'h400, 64'h480, 3, 64'd0);
        run_xfer(1'b0, 64'h400, 64'h480, 16'd8, 64'd0, 3, 0);
        n_chk++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL abort_count got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_acc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (obs_done !== 0) begin n_fail++; $display("FAIL abort_done got cycle %0d want none", obs_done); end
        n_chk++; if (obs_fall !== 7) begin n_fail++; $display("FAIL abort_busy_fall got %0d want 7", obs_fall); end
        model(1'b1, 64'h0, 64'h500, 2, 64'hCAFE);
        run_xfer(1'b1, 64'h0, 64'h500, 16'd2, 64'hCAFE, 0, 0);
        n_chk++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL abort_restart_done got %0d want %0d", obs_done, exp_done); end
    endtask

    task automatic test_reset_mid();
        model(1'b1, 64'h0, 64'h200, 3, 64'h5A5A);
        @(negedge clk);
        mode = 1'b1; dst = 64'h200; len = 16'd10; fillv = 64'h5A5A; start = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({W_en, R_en, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async got %b want 000", {W_en, R_en, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle got %b want 00", {busy, done}); end
        model(1'b1, 64'h0, 64'h600, 4, 64'hBEEF);
        run_xfer(1'b1, 64'h0, 64'h600, 16'd4, 64'hBEEF, 0, 2);
        n_chk++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL busy_start_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_acc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (obs_done !== 5) begin n_fail++; $display("FAIL busy_start_done got %0d want 5", obs_done); end
    endtask

    task automatic test_wrap_overlap();
        model(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 2, 64'h77);
        run_xfer(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 64'h77, 0, 0);
        n_chk++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", obs_q.size()); end
        else begin
            n_chk++; if (obs_q[0][127:64] !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr0 got %h want fff8", obs_q[0][127:64]); end
            n_chk++; if (obs_q[1][127:64] !== 64'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", obs_q[1][127:64]); end
        end
        model(1'b0, 64'h300, 64'h308, 4, 64'd0);
        run_xfer(1'b0, 64'h300, 64'h308, 16'd4, 64'd0, 0, 0);
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL overlap_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL overlap_acc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic        m;
        logic [63:0] s, d, f;
        logic [15:0] n;
        for (int k = 0; k < 8; k++) begin
            m = 1'($urandom_range(0, 1));
            s = {$urandom, $urandom};
            d = {$urandom, $urandom};
            f = {$urandom, $urandom};
            n = 16'($urandom_range(0, 12));
            model(m, s, d, int'(n), f);
            run_xfer(m, s, d, n, f, 0, 0);
            n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", k, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_acc%0d got %h want %h", k, i, obs_q[i], exp_q[i]); end
            end
            n_chk++; if (obs_done !== exp_done || obs_fall !== exp_done) begin n_fail++; $display("FAIL rand%0d_timing got done %0d fall %0d want %0d", k, obs_done, obs_fall, exp_done); end
            n_chk++; if (obs_both !== 0 || obs_rwt_bad !== 0) begin n_fail++; $display("FAIL rand%0d_bus got both %0d rwt %0d want 0/0", k, obs_both, obs_rwt_bad); end
        end
    endtask

    task automatic test_mem_final();
        int bad;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) bad++;
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL mem_final got %0d differing words want 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom};
            refmem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_fill();
        test_copy();
        test_len0_misalign();
        test_abort();
        test_reset_mid();
        test_wrap_overlap();
        test_random();
        test_mem_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
